// File: rtl/sat_pkg.sv
// sat_pkg: shared opcodes and width-parametrised saturation limits
package sat_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  // Largest positive two's complement value of a w-bit word (w <= 64)
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value of a w-bit word (w <= 64)
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_add_core.sv
// sat_add_core: exact signed add/sub with optional saturation and result flags
module sat_add_core
  import sat_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             ov,
  output logic             neg,
  output logic             zr
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] ax, bx, r;

  // One extra bit makes both sum and difference exact, including b = MIN on subtract
  assign ax = {a[WIDTH-1], a};
  assign bx = {b[WIDTH-1], b};
  assign r  = sub ? ax - bx : ax + bx;
  assign ov = r[WIDTH] ^ r[WIDTH-1];

  // Clamp toward the true sign (r[WIDTH]) on overflow; flags keep the legacy raw-sign convention
  always_comb begin
    result = (ov && SAT_EN) ? (r[WIDTH] ? MIN : MAX) : r[WIDTH-1:0];
    neg    = ov ? r[WIDTH-1] : result[WIDTH-1];
    zr     = ~ov & (result == '0);
  end

endmodule

// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: 2-stage valid/ready saturating add/sub/accumulate pipeline
module sat_addsub_pipe
  import sat_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             neg,
  output logic             ov,
  output logic [WIDTH-1:0] acc,
  output logic             ov_sticky,
  input  logic             clr_sticky
);

  logic             s1_v;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s2_ready, xfer;
  logic [WIDTH-1:0] a, res;
  logic             sub, c_ov, c_neg, c_zr;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~s1_v | s2_ready;
  assign xfer     = s1_v & s2_ready;

  // Operand A: the accumulator for ACC, zero for LOAD so the core passes in2 through unflagged
  always_comb begin
    a   = (s1_op == OP_ACC) ? acc : (s1_op == OP_LOAD) ? '0 : s1_a;
    sub = (s1_op == OP_SUB);
  end

  sat_add_core #(.WIDTH(WIDTH), .SAT_EN(SAT_EN)) u_core (
    .a      (a),
    .b      (s1_b),
    .sub    (sub),
    .result (res),
    .ov     (c_ov),
    .neg    (c_neg),
    .zr     (c_zr)
  );

  // Stage 1 input register; holds its op while stage 2 is blocked
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_op <= OP_ADD;
      s1_a  <= '0;
      s1_b  <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (in_valid && in_ready) begin
        s1_op <= op_t'(op);
        s1_a  <= in1;
        s1_b  <= in2;
      end
    end

  // Stage 2 result register; frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      neg       <= 1'b0;
      ov        <= 1'b0;
    end else begin
      if (s2_ready) out_valid <= s1_v;
      if (xfer) begin
        out <= res;
        zr  <= c_zr;
        neg <= c_neg;
        ov  <= c_ov;
      end
    end

  // Accumulator commits as the op leaves stage 1, so a following ACC sees it with no bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (xfer && (s1_op == OP_ACC || s1_op == OP_LOAD)) acc <= res;

  // Sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ov_sticky <= 1'b0;
    else if (xfer && c_ov) ov_sticky <= 1'b1;
    else if (clr_sticky) ov_sticky <= 1'b0;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// tb_sat_addsub_pipe: table vectors plus directed stall/sticky/reset sequences, scoreboard-checked
module tb_sat_addsub_pipe;

  typedef struct {
    logic [15:0] o;
    logic        zr, neg, ov;
    logic [15:0] acc;
  } res_t;

  typedef struct {
    res_t s, w;
    int   cyc;
    bit   lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, o;
    logic        zr, neg, ov;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, clr_sticky = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [15:0] in1 = '0, in2 = '0;
  logic        in_ready, out_valid, zr, neg, ov, ov_sticky;
  logic [15:0] out, acc;
  logic        w_in_ready, w_out_valid, w_zr, w_neg, w_ov, w_ov_sticky;
  logic [15:0] w_out, w_acc;

  int          n_vec = 0, n_fail = 0, cyc = 0, acc_cyc = 0, t0 = 0;
  bit          nobp = 0;
  logic [15:0] acc_s = '0, acc_w = '0;
  exp_t        q[$];
  vec_t        vt[16];
  vec_t        nv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sat_addsub_pipe #(.WIDTH(16), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .neg(neg), .ov(ov), .acc(acc), .ov_sticky(ov_sticky), .clr_sticky(clr_sticky)
  );

  sat_addsub_pipe #(.WIDTH(16), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .op(op),
    .in1(in1), .in2(in2), .out_valid(w_out_valid), .out_ready(out_ready), .out(w_out),
    .zr(w_zr), .neg(w_neg), .ov(w_ov), .acc(w_acc), .ov_sticky(w_ov_sticky), .clr_sticky(clr_sticky)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Integer reference model, independent of bit-level tricks
  function automatic res_t model(input logic [1:0] o, input logic [15:0] a, b, acc_in, input bit sat);
    int   x, y, r;
    res_t e;
    x = (o == 2'd2) ? int'($signed(acc_in)) : (o == 2'd3) ? 0 : int'($signed(a));
    y = int'($signed(b));
    r = (o == 2'd1) ? x - y : x + y;
    e.ov  = (r > 32767) || (r < -32768);
    e.o   = (e.ov && sat) ? ((r > 0) ? 16'h7fff : 16'h8000) : 16'(r);
    e.neg = e.ov ? (r > 0) : e.o[15];
    e.zr  = !e.ov && (e.o == 16'h0000);
    e.acc = o[1] ? e.o : acc_in;
    return e;
  endfunction

  task automatic drive(input logic [1:0] o, input logic [15:0] a, b, input bit use_exp, input vec_t v);
    exp_t e;
    bit   got = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 want accept within 64 cycles");
    end else begin
      e.s = model(o, a, b, acc_s, 1'b1);
      e.w = model(o, a, b, acc_w, 1'b0);
      if (use_exp) begin
        e.s.o = v.o; e.s.zr = v.zr; e.s.neg = v.neg; e.s.ov = v.ov;
        e.s.acc = o[1] ? v.o : acc_s;
      end
      acc_s = e.s.acc;
      acc_w = e.w.acc;
      e.cyc = cyc;
      e.lat = nobp;
      q.push_back(e);
      acc_cyc = cyc;
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard: compare both instances whenever a result leaves stage 2
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 32'(out), 32'hdead_beef);
      else begin
        e = q.pop_front();
        chk("out", 32'(out), 32'(e.s.o));
        chk("zr", 32'(zr), 32'(e.s.zr));
        chk("neg", 32'(neg), 32'(e.s.neg));
        chk("ov", 32'(ov), 32'(e.s.ov));
        chk("acc", 32'(acc), 32'(e.s.acc));
        chk("w_valid", 32'(w_out_valid), 32'd1);
        chk("w_out", 32'(w_out), 32'(e.w.o));
        chk("w_zr", 32'(w_zr), 32'(e.w.zr));
        chk("w_neg", 32'(w_neg), 32'(e.w.neg));
        chk("w_ov", 32'(w_ov), 32'(e.w.ov));
        chk("w_acc", 32'(w_acc), 32'(e.w.acc));
        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  initial begin
    //         op     a         b         o         zr    neg   ov
    vt[0]  = '{2'd0, 16'h7000, 16'h2000, 16'h7fff, 1'b0, 1'b1, 1'b1};
    vt[1]  = '{2'd1, 16'h0000, 16'h8000, 16'h7fff, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{2'd1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{2'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{2'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{2'd0, 16'hffff, 16'hffff, 16'hfffe, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{2'd3, 16'h1111, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{2'd2, 16'h2222, 16'hfffd, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{2'd2, 16'h0000, 16'h7fff, 16'h7fff, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{2'd2, 16'h0000, 16'h0001, 16'h7fff, 1'b0, 1'b1, 1'b1};
    vt[10] = '{2'd3, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[11] = '{2'd2, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1};
    vt[12] = '{2'd0, 16'h7fff, 16'h0001, 16'h7fff, 1'b0, 1'b1, 1'b1};
    vt[13] = '{2'd1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[14] = '{2'd1, 16'h7fff, 16'h8000, 16'h7fff, 1'b0, 1'b1, 1'b1};
    vt[15] = '{2'd0, 16'h8000, 16'h7fff, 16'hffff, 1'b0, 1'b1, 1'b0};
    nv = vt[0];

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_flags", 32'({zr, neg, ov}), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_sticky", 32'(ov_sticky), 32'd0);
    rst_n = 1'b1;

    // Back-to-back table at full throughput
    nobp = 1;
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b, 1'b1, vt[i]);
      if (i == 0) t0 = acc_cyc;
    end
    chk("throughput", 32'(acc_cyc - t0), 32'd15);
    idle();
    drain();
    nobp = 0;
    chk("sticky_set", 32'(ov_sticky), 32'd1);

    // Plain clear
    @(posedge clk); #1; clr_sticky = 1'b1;
    @(posedge clk); #1; clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_clr", 32'(ov_sticky), 32'd0);

    // Clear held while an overflowing op moves into stage 2: set wins
    @(posedge clk); #1; clr_sticky = 1'b1;
    drive(2'd0, 16'h7000, 16'h2000, 1'b0, nv);
    idle();
    @(negedge clk);
    chk("sticky_early", 32'(ov_sticky), 32'd0);
    @(negedge clk);
    chk("sticky_setwins", 32'(ov_sticky), 32'd1);
    @(posedge clk); #1; clr_sticky = 1'b0;
    drain();

    // Back-pressure: two ops fill the pipe, third waits
    @(posedge clk); #1; out_ready = 1'b0;
    drive(2'd3, 16'h0000, 16'h0001, 1'b0, nv);
    drive(2'd2, 16'h0000, 16'h0001, 1'b0, nv);
    @(posedge clk); #1;
    in_valid = 1'b1; op = 2'd2; in1 = 16'h0000; in2 = 16'h0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out", 32'(out), 32'h0001);
      chk("stall_acc", 32'(acc), 32'h0001);
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'd2, 16'h0000, 16'h0001, 1'b0, nv);
    idle();
    drain();

    // Asynchronous reset with an op held in stage 2
    @(posedge clk); #1; out_ready = 1'b0;
    drive(2'd3, 16'h0000, 16'h0055, 1'b0, nv);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_acc", 32'(acc), 32'h0055);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_acc", 32'(acc), 32'd0);
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_sticky", 32'(ov_sticky), 32'd0);
    q.delete();
    acc_s = '0;
    acc_w = '0;
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Accumulator restarts from zero
    drive(2'd2, 16'h0000, 16'h0005, 1'b0, nv);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
